// File: rtl/rotate_ctrl_debounce_if.sv
// Button/status bundle between the board-facing control stage and its user.
// Master drives the raw buttons and observes the conditioned levels; slave is the debouncer.
interface rotate_ctrl_debounce_if;
    logic btn_en_raw;
    logic btn_dir_raw;
    logic en;
    logic cw;
    logic btn_evt;

    modport master (output btn_en_raw, output btn_dir_raw, input en, input cw, input btn_evt);
    modport slave  (input btn_en_raw, input btn_dir_raw, output en, output cw, output btn_evt);
endinterface

// File: rtl/rotate_ctrl_debounce.sv
// Run/pause and direction pushbutton conditioning: sync, debounce FSM, toggle registers.
// Optional long-press restore of en=1/cw=1 is built when ROTATE_CTRL_LONG_PRESS_EN is defined.

module rotate_ctrl_debounce_lane #(
    parameter int DEBOUNCE_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic accept,
    output logic held,
    output logic idle
);
    localparam int CW = $clog2(DEBOUNCE_CNT);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

    state_t          state_q, state_d;
    logic            s1_q, s1_d, s2_q, s2_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cnt_done;

    assign cnt_done = (cnt_q == CW'(DEBOUNCE_CNT - 1));

    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (cnt_done) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = REL_WAIT;
                    cnt_d   = '0;
                end
            end
            REL_WAIT: begin
                // A bounce back high returns straight to HELD without a new toggle
                if (s2_q) begin
                    state_d = HELD;
                end else if (cnt_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign held = (state_q == HELD);
    assign idle = (state_q == IDLE);
endmodule

module rotate_ctrl_debounce #(
    parameter int DEBOUNCE_CNT   = 1_000_000,
    parameter int LONG_PRESS_CNT = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rotate_ctrl_debounce_if.slave bus
);
    localparam int NUM_LANES = 2;

    if (DEBOUNCE_CNT < 2 || LONG_PRESS_CNT < 2) begin : g_bad_param
        $error("rotate_ctrl_debounce: DEBOUNCE_CNT and LONG_PRESS_CNT must be >= 2");
    end

    // Lane 0 = run/pause, lane 1 = direction
    logic [NUM_LANES-1:0] raw, accept, held, idle;
    assign raw = {bus.btn_dir_raw, bus.btn_en_raw};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        rotate_ctrl_debounce_lane #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (raw[i]),
            .accept (accept[i]),
            .held   (held[i]),
            .idle   (idle[i])
        );
    end

    logic en_q, en_d, cw_q, cw_d, evt_q, evt_d;

`ifdef ROTATE_CTRL_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_PRESS_CNT);

    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          lp_done_q, lp_done_d;
    logic          lp_fire;

    // lp_done survives REL_WAIT bounces so one physical hold restores only once
    always_comb begin
        lcnt_d    = lcnt_q;
        lp_done_d = lp_done_q;
        lp_fire   = 1'b0;
        if (held[0]) begin
            if (lcnt_q != LW'(LONG_PRESS_CNT - 1)) begin
                lcnt_d = lcnt_q + 1'b1;
            end else if (!lp_done_q) begin
                lp_fire   = 1'b1;
                lp_done_d = 1'b1;
            end
        end else begin
            lcnt_d = '0;
        end
        if (idle[0]) lp_done_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lcnt_q    <= '0;
            lp_done_q <= 1'b0;
        end else begin
            lcnt_q    <= lcnt_d;
            lp_done_q <= lp_done_d;
        end
    end

    wire unused_lane = ^{held[1], idle[1]};
`else
    logic lp_fire;
    assign lp_fire = 1'b0;

    wire unused_lane = ^{held, idle};
`endif

    // Restore overrides any direction toggle landing on the same edge
    always_comb begin
        en_d  = en_q ^ accept[0];
        cw_d  = cw_q ^ accept[1];
        evt_d = |accept;
        if (lp_fire) begin
            en_d  = 1'b1;
            cw_d  = 1'b1;
            evt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q  <= 1'b1;
            cw_q  <= 1'b1;
            evt_q <= 1'b0;
        end else begin
            en_q  <= en_d;
            cw_q  <= cw_d;
            evt_q <= evt_d;
        end
    end

    assign bus.en      = en_q;
    assign bus.cw      = cw_q;
    assign bus.btn_evt = evt_q;
endmodule
